packet_wb_arbiter: RTL
======================

Name: packet_wb_arbiter

Overview:
- Arbitrates packet writebacks into the packet SRAM controller's single write slot.
- Requesters are the dispatcher (DP) and NUM_PE Edge PEs.
- DP has priority over all PEs. A starvation guard bounds how long a waiting PE can be blocked. PEs are served among themselves in round-robin order.
- One registered output slot with a valid/ready handshake. Every requester is back-pressured, so no writeback packet is ever dropped.

Parameters:
- NUM_PE, 4, number of Edge PE requesters (matches `Num_Edge_PE).
- PACKET_W, 64, packet width in bits (matches `packet_size).
- DP_BURST_MAX, 4, maximum consecutive DP grants while any PE is waiting.
- SRC_W, $clog2(NUM_PE+1), width of the source tag.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear, asserted on replay_iter_flag.
- drain_req  input  1  stop accepting new grants (cntl_done); level or pulse.
- dp_valid  input  1  DP packet request.
- dp_packet  input  PACKET_W  DP packet.
- dp_ready  output  1  DP packet accepted this cycle.
- pe_valid  input  NUM_PE  per-PE request.
- pe_packet  input  NUM_PE*PACKET_W  per-PE packet; PE i occupies bits [i*PACKET_W +: PACKET_W].
- pe_ready  output  NUM_PE  per-PE accept, one-hot or zero.
- out_valid  output  1  output slot holds a packet.
- out_packet  output  PACKET_W  packet sent to the SRAM controller.
- out_src  output  SRC_W  source tag: 0 = DP, i+1 = PE i.
- out_ready  input  1  controller consumes the slot this cycle.
- drained  output  1  in DONE state.
- grant_cnt  output  16  total accepted packets; wraps at 2^16.

Behaviour:
- Reset (asynchronous) values:
  - out_valid=0, out_packet=0, out_src=0, grant_cnt=0.
  - rr_ptr=0, dp_streak=0, state=RUN, drained=0.
  - dp_ready and pe_ready are combinational and are 0 whenever state!=RUN or flush=1.
- Handshake:
  - A transfer happens when valid&ready are both high in the same cycle.
  - A requester holds valid and its packet stable until it sees ready.
  - Ready never depends on that requester's own packet contents.
- Slot load: load_en = (state==RUN) & !flush & (!out_valid | out_ready).
  - At most one ready is high per cycle, and only when load_en=1.
  - The accepted packet appears on out_* at the next edge: 1-cycle latency, full throughput.
- Slot clear: if out_ready & out_valid and nothing is loaded, out_valid goes to 0 next cycle.
  - out_ready while out_valid=0 is ignored.
- Winner selection (when load_en=1):
  - pe_any = |pe_valid.
  - If dp_valid and not (pe_any & dp_streak==DP_BURST_MAX): DP wins.
  - Else if pe_any: the PE wins whose index is first found searching upward from rr_ptr, wrapping modulo NUM_PE.
  - Else: no grant.
- dp_streak:
  - +1 on a DP grant with pe_any=1.
  - Set to 0 on any PE grant, and on any cycle with pe_any=0.
  - Saturates at DP_BURST_MAX.
- rr_ptr: after a grant to PE i, rr_ptr=(i+1) mod NUM_PE. Unchanged otherwise.
- grant_cnt: +1 per accepted packet (DP or PE).
- State machine:
  - RUN -> DRAIN when drain_req=1. No grant occurs in that cycle.
  - DRAIN -> DONE when out_valid=0, or out_valid&out_ready (slot empties this cycle).
  - DONE holds; drained=1.
  - Any state -> RUN on flush.
  - flush has priority over drain_req.
- flush:
  - Next cycle: out_valid=0, rr_ptr=0, dp_streak=0, grant_cnt=0, state=RUN.
  - The output slot's packet is discarded.
  - No ready is asserted during the flush cycle.
- Simultaneous events:
  - Load and drain of the slot in the same cycle: the slot is replaced, and out_valid stays 1.
  - drain_req and a pending request in the same cycle: the request is not granted.
- Reset mid-transfer: the slot contents are lost. Requesters still hold valid and are re-served after reset is released.

Decomposition:
- Shared package (alongside DP2mem_packet / com_packet):
  - typedef wb_req_t {valid, packet}.
  - typedef wb_out_t {valid, src, packet}.
  - Constants for DP_BURST_MAX and SRC_W.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[NUM_PE], ptr.
  - Outputs: gnt one-hot, idx, any.
  - Reusable by the other arbiters in the design.
- Top level holds the FSM, streak counter, pointer, output slot and grant counter.

Test Plan:
- Single DP request: dp_valid=1 with 0xA5 -> dp_ready that cycle; out_valid=1, out_packet=0xA5, out_src=0 next cycle; grant_cnt=1.
- PE round-robin: pe_valid=4'b1111 held, out_ready=1 -> grants PE0,1,2,3,0 on consecutive cycles; out_src=1,2,3,4,1.
- Starvation guard: dp_valid=1 and pe_valid=4'b0100 held, DP_BURST_MAX=4 -> 4 DP grants, then PE2 (out_src=3), then DP; streak restarts.
- Back-pressure: out_ready=0 with out_valid=1 and dp_valid=1 -> dp_ready=0 and out_packet stable. Raise out_ready -> the slot is replaced in the same cycle and out_valid never drops.
- Drain: drain_req pulsed with out_valid=1, out_ready=0 for 3 cycles -> no ready asserted, drained=0. out_ready=1 -> drained=1 next cycle, and stays 1 while requests continue.
- Flush: flush with out_valid=1, grant_cnt=7, rr_ptr=2 -> next cycle out_valid=0, grant_cnt=0, state=RUN; then pe_valid=4'b1111 -> PE0 granted first.

Source files
------------

// File: rtl/packet_wb_arbiter_pkg.sv
// Shared types and constants for the packet writeback arbiter and its round-robin picker.
package packet_wb_arbiter_pkg;

  localparam int unsigned NUM_PE       = 4;
  localparam int unsigned PACKET_W     = 64;
  localparam int unsigned DP_BURST_MAX = 4;
  localparam int unsigned SRC_W        = $clog2(NUM_PE + 1);
  localparam int unsigned PTR_W        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned STREAK_W     = $clog2(DP_BURST_MAX + 1);
  localparam int unsigned CNT_W        = 16;

  typedef struct packed {
    logic                valid;
    logic [PACKET_W-1:0] packet;
  } wb_req_t;

  typedef struct packed {
    logic                valid;
    logic [SRC_W-1:0]    src;
    logic [PACKET_W-1:0] packet;
  } wb_out_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  // Source tag of PE idx; tag 0 is reserved for the dispatcher.
  function automatic logic [SRC_W-1:0] pe_src(input logic [PTR_W-1:0] idx);
    return SRC_W'(idx) + SRC_W'(1);
  endfunction

endpackage

// File: rtl/packet_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module packet_wb_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned c;
    logic        found;
    c     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!found && req[PW'(c)]) begin
        found        = 1'b1;
        gnt[PW'(c)]  = 1'b1;
        idx          = PW'(c);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/packet_wb_arbiter.sv
// Writeback arbiter: DP priority with starvation guard, round-robin among PEs,
// single registered output slot with valid/ready handshake.
module packet_wb_arbiter
  import packet_wb_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       drain_req,
  input  logic                       dp_valid,
  input  logic [PACKET_W-1:0]        dp_packet,
  output logic                       dp_ready,
  input  logic [NUM_PE-1:0]          pe_valid,
  input  logic [NUM_PE*PACKET_W-1:0] pe_packet,
  output logic [NUM_PE-1:0]          pe_ready,
  output logic                       out_valid,
  output logic [PACKET_W-1:0]        out_packet,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_ready,
  output logic                       drained,
  output logic [CNT_W-1:0]           grant_cnt
);

  arb_state_e            state, state_next;
  wb_out_t               slot;
  wb_req_t               dp_req;
  wb_req_t               pe_req [NUM_PE];
  logic [PTR_W-1:0]      rr_ptr;
  logic [STREAK_W-1:0]   dp_streak;
  logic [NUM_PE-1:0]     pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pe_any;
  logic                  grant_en;
  logic                  dp_win;
  logic                  pe_win;

  always_comb begin
    dp_req = '{valid: dp_valid, packet: dp_packet};
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      pe_req[i] = '{valid: pe_valid[i], packet: pe_packet[i*PACKET_W +: PACKET_W]};
    end
  end

  packet_wb_arbiter_rr_pick #(.N(NUM_PE), .PW(PTR_W)) u_rr_pick (
    .req (pe_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pe_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Grant decision and next state; readies held low during reset so no packet is lost.
  always_comb begin
    state_next = state;
    dp_ready   = 1'b0;
    pe_ready   = '0;
    grant_en   = (state == ST_RUN) && !flush && !drain_req && !reset &&
                 (!slot.valid || out_ready);
    dp_win     = grant_en && dp_req.valid &&
                 !(pe_any && (dp_streak == STREAK_W'(DP_BURST_MAX)));
    pe_win     = grant_en && !dp_win && pe_any;
    dp_ready   = dp_win;
    if (pe_win) pe_ready = pick_gnt;
    if (flush) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (drain_req) state_next = ST_DRAIN;
        ST_DRAIN: if (!slot.valid || out_ready) state_next = ST_DONE;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (flush) begin
      slot <= '0;
    end else if (dp_win) begin
      slot <= '{valid: 1'b1, src: '0, packet: dp_req.packet};
    end else if (pe_win) begin
      slot <= '{valid: 1'b1, src: pe_src(pick_idx), packet: pe_req[pick_idx].packet};
    end else if (out_ready) begin
      slot.valid <= 1'b0;
    end
  end

  // Streak only counts DP wins while some PE is actually waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_streak <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else if (flush) begin
      dp_streak <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else begin
      if (pe_win || !pe_any) begin
        dp_streak <= '0;
      end else if (dp_win && (dp_streak != STREAK_W'(DP_BURST_MAX))) begin
        dp_streak <= dp_streak + STREAK_W'(1);
      end
      if (pe_win) begin
        rr_ptr <= (pick_idx == PTR_W'(NUM_PE - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
      if (dp_win || pe_win) grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = slot.valid;
  assign out_packet = slot.packet;
  assign out_src    = slot.src;
  assign drained    = (state == ST_DONE);

endmodule
